// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - elastic pipeline-stage register with 2-entry skid buffer and bubble counter
module pipe_stage_skid #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CTRL_W-1:0]   m_ctrl_q, m_ctrl_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic [CTRL_W-1:0]   s_ctrl_q, s_ctrl_d;
    logic [DATA_W-1:0]   s_data_q, s_data_d;
    logic                in_ready_q, in_ready_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                m_valid;
    logic                accept;
    logic                pop;

    assign m_valid = (state_q != ST_EMPTY);
    assign accept  = in_valid & in_ready_q;
    assign pop     = m_valid & out_ready;

    always_comb begin
        state_d  = state_q;
        m_ctrl_d = m_ctrl_q;
        m_data_d = m_data_q;
        s_ctrl_d = s_ctrl_q;
        s_data_d = s_data_q;
        // A flush discards everything, including an input accepted this same edge.
        if (flush) begin
            state_d  = ST_EMPTY;
            m_ctrl_d = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        m_ctrl_d = in_ctrl;
                        m_data_d = in_data;
                        state_d  = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        m_ctrl_d = in_ctrl;
                        m_data_d = in_data;
                    end else if (accept) begin
                        s_ctrl_d = in_ctrl;
                        s_data_d = in_data;
                        state_d  = ST_FULL;
                    end else if (pop) begin
                        m_ctrl_d = '0;
                        state_d  = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        m_ctrl_d = s_ctrl_q;
                        m_data_d = s_data_q;
                        state_d  = ST_ONE;
                    end
                end
                default: begin
                    m_ctrl_d = '0;
                    state_d  = ST_EMPTY;
                end
            endcase
        end
    end

    // in_ready depends only on next state, so out_ready never reaches it combinationally.
    always_comb begin
        in_ready_d = (state_d != ST_FULL);
        cnt_d      = cnt_q;
        if (!m_valid && out_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_EMPTY;
            m_ctrl_q   <= '0;
            m_data_q   <= '0;
            s_ctrl_q   <= '0;
            s_data_q   <= '0;
            in_ready_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            m_ctrl_q   <= m_ctrl_d;
            m_data_q   <= m_data_d;
            s_ctrl_q   <= s_ctrl_d;
            s_data_q   <= s_data_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = m_valid;
    assign out_ctrl   = m_ctrl_q;
    assign out_data   = m_data_q;
    assign bubble_cnt = cnt_q;

    a_ctrl_zero_on_bubble: assert property (@(posedge clk) out_valid || (out_ctrl == '0));
    a_reset_holds_idle: assert property (@(posedge clk)
        !rst |=> (!out_valid && !in_ready && (bubble_cnt == '0)));

endmodule
